// File: rtl/jk_excitation_driver_pkg.sv
// Shared types and constants for the JK excitation driver.
//   state_t            : controller states (IDLE / APPLY / WAIT)
//   DC_HOLD_SET_RESET  : excitation mode 0, per-bit hold/set/reset codes
//   DC_TOGGLE          : excitation mode 1, per-bit toggle code on mismatch
package jk_excitation_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic DC_HOLD_SET_RESET = 1'b0;
  localparam logic DC_TOGGLE         = 1'b1;

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Target handshake and status bundle of the JK excitation driver.
//   tgt_valid / tgt_ready / tgt_data : target word offer and acceptance
//   busy / done / err                : operation status and completion pulses
// master = target source, slave = jk_excitation_driver.
interface jk_excitation_driver_if #(
  parameter int W = 4
);
  logic         tgt_valid;
  logic         tgt_ready;
  logic [W-1:0] tgt_data;
  logic         busy;
  logic         done;
  logic         err;

  modport master (output tgt_valid, tgt_data, input tgt_ready, busy, done, err);
  modport slave  (input tgt_valid, tgt_data, output tgt_ready, busy, done, err);
endinterface

// File: rtl/jk_excitation_driver_excite_bit.sv
// jk_excite_bit: combinational excitation for one JK flop.
//   c    : current Q of the flop
//   t    : requested Q
//   mode : DC_HOLD_SET_RESET or DC_TOGGLE
//   j, k : excitation that moves c to t on the next master/slave transfer
module jk_excite_bit
  import jk_excitation_driver_pkg::*;
(
  input  logic c,
  input  logic t,
  input  logic mode,
  output logic j,
  output logic k
);

  always_comb begin
    j = 1'b0;
    k = 1'b0;
    if (c != t) begin
      if (mode == DC_TOGGLE) begin
        j = 1'b1;
        k = 1'b1;
      end else begin
        j = t;
        k = ~t;
      end
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: drives a bank of W master-slave JK flops to a target
// word, checks the Q readback after settling, and retries on mismatch.
//   clk, rst_n : system clock, async active-low reset
//   tgt        : target handshake + busy/done/err status (slave modport)
//   j, k       : registered excitation to the flop bank (zero outside APPLY)
//   q_fb       : Q readback from the flop bank
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready for a target, j/k = 0
// ST_APPLY | j/k presented for one cycle; bank master samples on exit
// ST_WAIT  | j/k = 0, count SETTLE edges, then compare q_fb to target
module jk_excitation_driver
  import jk_excitation_driver_pkg::*;
#(
  parameter int W         = 4,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 2,
  parameter int DC_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  jk_excitation_driver_if.slave   tgt,
  output logic [W-1:0]            j,
  output logic [W-1:0]            k,
  input  logic [W-1:0]            q_fb
);

  localparam int   RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int   SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic MODE = (DC_MODE == 1) ? DC_TOGGLE : DC_HOLD_SET_RESET;

  state_t          state, state_n;
  logic [W-1:0]    target, target_n;
  logic [W-1:0]    j_n, k_n;
  logic [RW-1:0]   retry, retry_n;
  logic [SW-1:0]   settle, settle_n;
  logic            done_q, done_n;
  logic            err_q, err_n;

  // In IDLE the excitation is computed from the incoming word; on a retry
  // it is recomputed from the latched target against the live readback.
  logic [W-1:0]    ex_t, ex_j, ex_k;

  assign ex_t = (state == ST_IDLE) ? tgt.tgt_data : target;

  for (genvar i = 0; i < W; i++) begin : g_bit
    jk_excite_bit u_bit (
      .c    (q_fb[i]),
      .t    (ex_t[i]),
      .mode (MODE),
      .j    (ex_j[i]),
      .k    (ex_k[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      target <= '0;
      j      <= '0;
      k      <= '0;
      retry  <= '0;
      settle <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      target <= target_n;
      j      <= j_n;
      k      <= k_n;
      retry  <= retry_n;
      settle <= settle_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    j_n      = '0;
    k_n      = '0;
    retry_n  = retry;
    settle_n = settle;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tgt.tgt_valid) begin
          target_n = tgt.tgt_data;
          j_n      = ex_j;
          k_n      = ex_k;
          retry_n  = '0;
          state_n  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        settle_n = '0;
        state_n  = ST_WAIT;
      end
      ST_WAIT: begin
        if (settle == SW'(SETTLE - 1)) begin
          if (q_fb == target) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else if (retry < RW'(MAX_RETRY)) begin
            retry_n = retry + RW'(1);
            j_n     = ex_j;
            k_n     = ex_k;
            state_n = ST_APPLY;
          end else begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end else begin
          settle_n = settle + SW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Gated with rst_n so a source never sees ready while reset is held.
  assign tgt.tgt_ready = rst_n & (state == ST_IDLE);
  assign tgt.busy      = (state != ST_IDLE);
  assign tgt.done      = done_q;
  assign tgt.err       = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver. Three instances cover the parameter
// corners: u0 (DC_MODE=0, SETTLE=1), u1 (DC_MODE=1, SETTLE=1),
// u2 (DC_MODE=0, SETTLE=2); all MAX_RETRY=2. Each drives its own behavioural
// master-slave JK bank with an optional stuck-at-0 mask.
module tb_jk_excitation_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  jk_excitation_driver_if #(.W(4)) bus0 ();
  jk_excitation_driver_if #(.W(4)) bus1 ();
  jk_excitation_driver_if #(.W(4)) bus2 ();

  logic [2:0]      valid_v = '0;
  logic [2:0][3:0] data_v  = '0;
  logic [2:0][3:0] q_v     = '0;
  logic [2:0][3:0] m_v     = '0;
  logic [2:0][3:0] stuck_v = '0;
  logic [2:0][3:0] j_o, k_o;
  logic [2:0]      rdy_o, busy_o, done_o, err_o;

  assign bus0.tgt_valid = valid_v[0];
  assign bus1.tgt_valid = valid_v[1];
  assign bus2.tgt_valid = valid_v[2];
  assign bus0.tgt_data  = data_v[0];
  assign bus1.tgt_data  = data_v[1];
  assign bus2.tgt_data  = data_v[2];
  assign rdy_o  = {bus2.tgt_ready, bus1.tgt_ready, bus0.tgt_ready};
  assign busy_o = {bus2.busy, bus1.busy, bus0.busy};
  assign done_o = {bus2.done, bus1.done, bus0.done};
  assign err_o  = {bus2.err, bus1.err, bus0.err};

  jk_excitation_driver #(.W(4), .SETTLE(1), .MAX_RETRY(2), .DC_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .tgt(bus0), .j(j_o[0]), .k(k_o[0]), .q_fb(q_v[0]));
  jk_excitation_driver #(.W(4), .SETTLE(1), .MAX_RETRY(2), .DC_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tgt(bus1), .j(j_o[1]), .k(k_o[1]), .q_fb(q_v[1]));
  jk_excitation_driver #(.W(4), .SETTLE(2), .MAX_RETRY(2), .DC_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .tgt(bus2), .j(j_o[2]), .k(k_o[2]), .q_fb(q_v[2]));

  // JK bank model: master captures Q+ = J~Q + ~KQ on posedge, slave on negedge.
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      m_v[i] <= (j_o[i] & ~q_v[i]) | (~k_o[i] & q_v[i]);
  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      q_v[i] <= m_v[i] & ~stuck_v[i];

  int settle_tab [3] = '{1, 1, 2};
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers tgt at the current negedge and follows the operation to done.
  // Applies occur every 1+SETTLE cycles starting one cycle after acceptance.
  task automatic run_op(input string tag, input int sel, input logic [3:0] tgt,
                        input logic [3:0] ej, input logic [3:0] ek,
                        input logic [3:0] eq, input logic eerr, input int applies);
    int s, exp_n, n;
    bit seen;
    s     = settle_tab[sel];
    exp_n = applies * (1 + s) + 1;
    check({tag, " ready"}, 32'(rdy_o[sel]), 32'd1);
    valid_v[sel] = 1'b1;
    data_v[sel]  = tgt;
    seen = 0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, " busy"}, 32'(busy_o[sel]), 32'd1);
      if (n < exp_n && ((n - 1) % (1 + s)) == 0) begin
        check($sformatf("%s j@%0d", tag, n), 32'(j_o[sel]), 32'(ej));
        check($sformatf("%s k@%0d", tag, n), 32'(k_o[sel]), 32'(ek));
      end
      if (done_o[sel] === 1'b1) begin
        seen = 1;
        check({tag, " latency"}, 32'(n), 32'(exp_n));
        check({tag, " err"}, 32'(err_o[sel]), 32'(eerr));
        check({tag, " q"}, 32'(q_v[sel]), 32'(eq));
      end
    end
    if (!seen) check({tag, " done timeout"}, 32'd0, 32'd1);
    valid_v[sel] = 1'b0;
  endtask

  typedef struct {
    int         sel;
    logic [3:0] tgt;
    logic [3:0] stuck;
    logic [3:0] ej;
    logic [3:0] ek;
    logic [3:0] eq;
    logic       eerr;
    int         applies;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{0, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 1'b0, 1};
    vt[1] = '{0, 4'b0110, 4'b0000, 4'b0100, 4'b1000, 4'b0110, 1'b0, 1};
    vt[2] = '{0, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 1'b0, 1};
    vt[3] = '{0, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 1'b0, 1};
    vt[4] = '{0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 3};
    vt[5] = '{1, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 1'b0, 1};
    vt[6] = '{1, 4'b0110, 4'b0000, 4'b1100, 4'b1100, 4'b0110, 1'b0, 1};
    vt[7] = '{2, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1};
    vt[8] = '{2, 4'b0011, 4'b0000, 4'b0010, 4'b0000, 4'b0011, 1'b0, 1};
    vt[9] = '{2, 4'b0111, 4'b0000, 4'b0100, 4'b0000, 4'b0111, 1'b0, 1};

    repeat (2) @(negedge clk);
    check("rst ready", 32'(rdy_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o | err_o), 32'd0);
    check("rst jk", 32'({j_o[0], k_o[0]}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post-rst ready", 32'(rdy_o), 32'b111);

    for (int v = 0; v < 10; v++) begin
      stuck_v[vt[v].sel] = vt[v].stuck;
      run_op($sformatf("vec%0d", v), vt[v].sel, vt[v].tgt, vt[v].ej, vt[v].ek,
             vt[v].eq, vt[v].eerr, vt[v].applies);
    end
    stuck_v[0] = 4'b0000;

    // Abort mid-operation: accept 1111 on u0, reset while in WAIT.
    valid_v[0] = 1'b1;
    data_v[0]  = 4'b1111;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort busy before rst", 32'(busy_o[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort jk", 32'({j_o[0], k_o[0]}), 32'd0);
    check("abort busy", 32'(busy_o[0]), 32'd0);
    check("abort ready", 32'(rdy_o[0]), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      check($sformatf("abort no done %0d", c), 32'(done_o[0]), 32'd0);
    end
    check("abort ready after", 32'(rdy_o[0]), 32'd1);
    // Bank master took 1111 at the APPLY exit edge before the reset.
    run_op("after-rst 1111", 0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1);
    run_op("after-rst 0101", 0, 4'b0101, 4'b0000, 4'b1010, 4'b0101, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
